cdc_fifo_clear_sequencer: RTL

Single-clock sequencer placed directly upstream of the source side of the clearable gray-code CDC FIFO. It passes a valid/ready stream through to the FIFO and turns a software clear request into a protocol-safe `src_clear_i` pulse. Before clearing, it lets any stalled beat complete, so upstream never sees valid withdrawn mid-handshake. It then tracks the FIFO's clear-pending indication until the two-sided clear sequence finishes, and reports done or timeout.

---
 rtl/cdc_fifo_clear_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cdc_fifo_clear_sequencer.sv
// cdc_fifo_clear_sequencer
//   Sits in front of the source side of the clearable gray-code CDC FIFO.
//   It passes the upstream valid/ready stream straight through. A software
//   clear request becomes a single protocol-safe src_clear pulse. A beat that
//   is stalled when the request arrives is allowed to finish first. The block
//   then follows the FIFO clear-pending flag until the clear has completed on
//   both sides.
//
//   Optional feature: define CDC_FIFO_CLEAR_SEQ_TIMEOUT_EN to build the
//   DRAIN/WAIT timeout counter and the clear_timeout_o pulse. When it is not
//   defined, those states wait indefinitely and clear_timeout_o is tied to 0.
//
// Ports
//   clk_i, rst_ni          clock, async active-low reset
//   clear_req_i            clear request (sampled in IDLE only)
//   clear_busy_o           high whenever not IDLE
//   clear_done_o           1-cycle pulse on completion
//   clear_timeout_o        1-cycle pulse on DRAIN/WAIT timeout
//   up_data_i/valid_i      upstream stream in; up_ready_o back-pressure out
//   fifo_data_o/valid_o    stream to FIFO source; fifo_ready_i from FIFO
//   fifo_clear_o           to FIFO src_clear_i
//   fifo_clear_pending_i   from FIFO src_clear_pending_o
module cdc_fifo_clear_sequencer #(
  parameter int unsigned WIDTH          = 1,
  parameter type         T              = logic [WIDTH-1:0],
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_req_i,
  output logic clear_busy_o,
  output logic clear_done_o,
  output logic clear_timeout_o,
  input  T     up_data_i,
  input  logic up_valid_i,
  output logic up_ready_o,
  output T     fifo_data_o,
  output logic fifo_valid_o,
  input  logic fifo_ready_i,
  output logic fifo_clear_o,
  input  logic fifo_clear_pending_i
);

  typedef enum logic [2:0] {IDLE, DRAIN, CLEAR, WAIT, DONE} state_e;

  state_e state_q, state_d;
  logic   stall_q, stall_d;
  logic   seen_q, seen_d;
  logic   tmo;

  assign fifo_data_o = up_data_i;

`ifdef CDC_FIFO_CLEAR_SEQ_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  assign tmo = (state_q == DRAIN || state_q == WAIT) &&
               (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Counter is zero whenever the FSM enters DRAIN or WAIT, because every
  // entry comes from a different state.
  always_comb begin
    cnt_d = '0;
    if ((state_q == DRAIN || state_q == WAIT) && state_d == state_q)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    stall_d         = stall_q;
    seen_d          = seen_q;
    fifo_valid_o    = up_valid_i;
    up_ready_o      = fifo_ready_i;
    fifo_clear_o    = 1'b0;
    clear_done_o    = 1'b0;
    clear_timeout_o = 1'b0;
    clear_busy_o    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        stall_d = fifo_valid_o & ~fifo_ready_i;
        if (clear_req_i)
          state_d = (up_valid_i & ~fifo_ready_i) ? DRAIN : CLEAR;
      end
      DRAIN: begin
        // stall_q still holds the stall captured on the request cycle, so a
        // drop of valid here is an upstream withdrawal of a stalled beat.
        if (up_valid_i & fifo_ready_i)          state_d = CLEAR;
        else if (stall_q & ~up_valid_i)         state_d = CLEAR;
        else if (tmo) begin
          clear_timeout_o = 1'b1;
          state_d         = CLEAR;
        end
      end
      CLEAR: begin
        fifo_clear_o = 1'b1;
        fifo_valid_o = 1'b0;
        up_ready_o   = 1'b0;
        seen_d       = 1'b0;
        state_d      = WAIT;
      end
      WAIT: begin
        fifo_valid_o = 1'b0;
        up_ready_o   = 1'b0;
        if (fifo_clear_pending_i) seen_d = 1'b1;
        if (seen_q & ~fifo_clear_pending_i) state_d = DONE;
        else if (tmo) begin
          clear_timeout_o = 1'b1;
          state_d         = IDLE;
        end
      end
      DONE: begin
        clear_done_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      stall_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      seen_q  <= seen_d;
    end
  end

endmodule
